// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver:
// frame width, transmitter state encoding and the default bit period.
package uart_pkg;

  localparam int DATA_W         = 8;
  localparam int OVERSAMPLE_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Width of a counter that wraps 0..os-1, kept at least one bit wide.
  function automatic int cnt_width(input int os);
    return (os > 2) ? $clog2(os) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_tick.sv
// Bit-period counter: counts enabled clocks 0..OVERSAMPLE-1 and flags the
// last clock of each bit period. Shared between the transmitter and receiver.
module uart_bit_tick import uart_pkg::*; #(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int               CNT_W = cnt_width(OVERSAMPLE);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Independent of clear so the accept path through data_ready stays loop-free.
  assign tick = enable & (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2, LSB first, one byte per valid/ready handshake.
// tx is a registered decode of the current state, so it trails the state by one clock.
module uart_tx import uart_pkg::*; #(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx,
  output logic              busy
);

  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d;
  logic              tick;
  logic              accept;
  logic              last_stop;

  uart_bit_tick #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_tick (
    .clk   (clk),
    .rst   (rst),
    .clear ((state_q == IDLE) | accept),
    .enable(state_q != IDLE),
    .tick  (tick)
  );

  assign last_stop  = (state_q == STOP) & tick & (stop_cnt_q == STOP_LAST);
  assign data_ready = (state_q == IDLE) | last_stop;
  assign accept     = data_valid & data_ready;
  assign busy       = (state_q != IDLE);
  assign tx         = tx_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d    = STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (last_stop) begin
          state_d = accept ? START : IDLE;
        end else if (tick) begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every accept (from IDLE or the final stop clock) starts a fresh frame.
    if (accept) begin
      shift_d    = data;
      bit_cnt_d  = '0;
      stop_cnt_d = 1'b0;
    end
  end

  always_comb begin
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: cycle-exact waveform checks plus a mid-bit sampling
// receiver model fed from a scoreboard of accepted bytes.
module tb_uart_tx;

  localparam int OS0 = 8;
  localparam int OS1 = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data0, data1;
  logic       valid0, valid1;
  logic       ready0, ready1;
  logic       tx0, tx1;
  logic       busy0, busy1;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] sb0[$];
  int         rx_count = 0;
  int         rx_before;
  int         rx_off;
  int         rx_k;
  logic       rx_act = 1'b0;
  logic [7:0] rx_byte;
  logic [8:0] rx_exp;

  always #5 clk = ~clk;

  uart_tx #(.OVERSAMPLE(OS0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .data(data0), .data_valid(valid0),
    .data_ready(ready0), .tx(tx0), .busy(busy0)
  );

  uart_tx #(.OVERSAMPLE(OS1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .data(data1), .data_valid(valid1),
    .data_ready(ready1), .tx(tx1), .busy(busy1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line level i clocks into a frame (i<0 means before the start bit).
  function automatic logic exp_bit(input logic [7:0] b, input int os, input int i);
    if (i < 0)      return 1'b1;
    if (i < os)     return 1'b0;
    if (i < 9 * os) return b[(i - os) / os];
    return 1'b1;
  endfunction

  // Present a byte, wait (bounded) for ready, let it be accepted; valid stays high.
  task automatic send0(input logic [7:0] b);
    int n = 0;
    data0  = b;
    valid0 = 1'b1;
    while (!ready0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check_eq("send_ready_timeout", 32'd0, 32'd1);
    sb0.push_back(b);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Receiver model on dut0: sample each bit in its middle, check the stop bit.
  always @(negedge clk) begin
    if (rst) begin
      rx_act = 1'b0;
      rx_off = 0;
    end else if (!rx_act) begin
      if (tx0 == 1'b0) begin
        rx_act = 1'b1;
        rx_off = 0;
      end
    end else begin
      rx_off++;
      if (rx_off == OS0 / 2) begin
        check_eq("rx_start", tx0, 1'b0);
      end else if (rx_off > OS0 / 2 && (rx_off - OS0 / 2) % OS0 == 0) begin
        rx_k = (rx_off - OS0 / 2) / OS0;
        if (rx_k <= 8) begin
          rx_byte[rx_k-1] = tx0;
        end else begin
          check_eq("rx_stop", tx0, 1'b1);
          if (sb0.size() > 0) rx_exp = {1'b0, sb0.pop_front()};
          else                rx_exp = 9'h100;
          check_eq("rx_byte", {23'd0, 1'b0, rx_byte}, {23'd0, rx_exp});
          $display("rx byte %02h (expected %03h)", rx_byte, rx_exp);
          rx_count++;
          rx_act = 1'b0;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; data0 = '0; data1 = '0; valid0 = 1'b0; valid1 = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx0, 1'b1);
    check_eq("rst_busy", busy0, 1'b0);
    check_eq("rst_ready", ready0, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_tx", tx0, 1'b1);
    check_eq("idle_ready", ready0, 1'b1);
    check_eq("idle_tx1", tx1, 1'b1);

    // Single frame 0xA5: exact waveform, one-clock latency, ready low 79 clocks.
    send0(8'hA5);
    valid0 = 1'b0;
    for (int c = 0; c <= 80; c++) begin
      check_eq("a5_tx", tx0, exp_bit(8'hA5, OS0, c - 1));
      if (c < 80) begin
        check_eq("a5_ready", ready0, c == 79);
        check_eq("a5_busy", busy0, 1'b1);
      end
      @(negedge clk);
    end
    check_eq("a5_end_busy", busy0, 1'b0);
    check_eq("a5_end_tx", tx0, 1'b1);
    repeat (10) @(negedge clk);

    // Back-to-back 0x00 then 0xFF with valid held: no gap, busy never drops.
    send0(8'h00);
    data0 = 8'hFF;
    sb0.push_back(8'hFF);
    for (int c = 0; c <= 160; c++) begin
      if (c == 80) valid0 = 1'b0;
      if (c <= 80) check_eq("b2b_tx0", tx0, exp_bit(8'h00, OS0, c - 1));
      else         check_eq("b2b_tx1", tx0, exp_bit(8'hFF, OS0, c - 81));
      if (c < 160) begin
        check_eq("b2b_busy", busy0, 1'b1);
        check_eq("b2b_ready", ready0, (c == 79) || (c == 159));
      end
      @(negedge clk);
    end
    repeat (10) @(negedge clk);

    // Valid pulsed mid-frame is ignored; line idles afterwards.
    send0(8'h11);
    valid0 = 1'b0;
    repeat (20) @(negedge clk);
    data0 = 8'h3C; valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    repeat (70) @(negedge clk);
    for (int c = 0; c < 30; c++) begin
      check_eq("ign_tx", tx0, 1'b1);
      check_eq("ign_busy", busy0, 1'b0);
      @(negedge clk);
    end

    // Reset in the middle of data bit 3, then a clean 0x5A frame.
    rx_before = rx_count;
    send0(8'hC3);
    valid0 = 1'b0;
    repeat (37) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_tx", tx0, 1'b1);
    check_eq("midrst_busy", busy0, 1'b0);
    check_eq("midrst_ready", ready0, 1'b1);
    sb0.delete();
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    send0(8'h5A);
    valid0 = 1'b0;
    repeat (100) @(negedge clk);
    check_eq("midrst_rx_count", rx_count - rx_before, 1);

    // Two stop bits, 4 clocks per bit, 0x81: 44-clock frame.
    data1 = 8'h81; valid1 = 1'b1;
    check_eq("d1_ready_idle", ready1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    valid1 = 1'b0;
    for (int c = 0; c <= 44; c++) begin
      check_eq("d1_tx", tx1, exp_bit(8'h81, OS1, c - 1));
      if (c < 44) begin
        check_eq("d1_busy", busy1, 1'b1);
        check_eq("d1_ready", ready1, c == 43);
      end
      @(negedge clk);
    end
    check_eq("d1_end_busy", busy1, 1'b0);
    check_eq("d1_end_tx", tx1, 1'b1);

    // Loopback of all 256 values back-to-back through the receiver model.
    rx_before = rx_count;
    for (int b = 0; b < 256; b++) send0(8'(b));
    valid0 = 1'b0;
    repeat (120) @(negedge clk);
    check_eq("loop_count", rx_count - rx_before, 256);
    check_eq("sb_empty", sb0.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
